// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package pipe_ctrl_pkg;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_e;

    // Architectural zero register: never a real dependency source.
    localparam int unsigned ZERO_REG = 32'd0;

endpackage : pipe_ctrl_pkg

// File: rtl/hazard_detect.sv
// Combinational register-dependency check between the ID stage and the EX/MEM stages.
module hazard_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_W = 5
) (
    input  logic             forward_en,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_two_src,
    input  logic [REG_W-1:0] ex_dest,
    input  logic             ex_wb_en,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] mem_dest,
    input  logic             mem_wb_en,
    output logic             hazard
);

    logic ex_hit_s;
    logic mem_hit_s;

    // Source/destination matching and forwarding-mode selection
    always_comb begin
        ex_hit_s  = 1'b0;
        mem_hit_s = 1'b0;
        hazard    = 1'b0;

        ex_hit_s  = ((id_src1 != REG_W'(ZERO_REG)) && (id_src1 == ex_dest) && ex_wb_en) ||
                    (id_two_src && (id_src2 != REG_W'(ZERO_REG)) && (id_src2 == ex_dest) && ex_wb_en);
        mem_hit_s = ((id_src1 != REG_W'(ZERO_REG)) && (id_src1 == mem_dest) && mem_wb_en) ||
                    (id_two_src && (id_src2 != REG_W'(ZERO_REG)) && (id_src2 == mem_dest) && mem_wb_en);

        // With forwarding only a load in EX cannot be bypassed in time.
        if (forward_en) begin
            hazard = ex_hit_s && ex_mem_read;
        end else begin
            hazard = ex_hit_s || mem_hit_s;
        end
    end

endmodule : hazard_detect

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stage enable/flush sequencer: hazards, taken branches, data-memory freezes,
// plus saturating debug counters for stall and flush events.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_W = 5,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             forward_en,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_two_src,
    input  logic [REG_W-1:0] ex_dest,
    input  logic             ex_wb_en,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] mem_dest,
    input  logic             mem_wb_en,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             mem_wb_en_o,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    state_e           state_r;
    state_e           state_nxt_s;
    logic             hazard_s;
    logic             frozen_s;
    logic             stall_inc_s;
    logic             flush_inc_s;
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;

    hazard_detect #(
        .REG_W (REG_W)
    ) u_hazard_detect (
        .forward_en  (forward_en),
        .id_src1     (id_src1),
        .id_src2     (id_src2),
        .id_two_src  (id_two_src),
        .ex_dest     (ex_dest),
        .ex_wb_en    (ex_wb_en),
        .ex_mem_read (ex_mem_read),
        .mem_dest    (mem_dest),
        .mem_wb_en   (mem_wb_en),
        .hazard      (hazard_s)
    );

    // Next-state and per-stage enable/flush decode
    always_comb begin
        state_nxt_s = state_r;
        frozen_s    = 1'b0;
        stall_inc_s = 1'b0;
        flush_inc_s = 1'b0;
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        if_id_flush = 1'b0;
        id_ex_en    = 1'b0;
        id_ex_flush = 1'b0;
        ex_mem_en   = 1'b0;
        mem_wb_en_o = 1'b0;

        case (state_r)
            RUN:      frozen_s = mem_req && !mem_ready;
            MEM_WAIT: frozen_s = !mem_ready;
            default:  frozen_s = 1'b0;
        endcase

        // Reset forces every enable low; the ready cycle of a wait resolves like RUN.
        if (rst) begin
            state_nxt_s = RUN;
        end else if (frozen_s) begin
            state_nxt_s = MEM_WAIT;
        end else begin
            state_nxt_s = RUN;
            if (branch_taken) begin
                pc_en       = 1'b1;
                if_id_en    = 1'b1;
                if_id_flush = 1'b1;
                id_ex_en    = 1'b1;
                id_ex_flush = 1'b1;
                ex_mem_en   = 1'b1;
                mem_wb_en_o = 1'b1;
                flush_inc_s = 1'b1;
            end else if (hazard_s) begin
                id_ex_en    = 1'b1;
                id_ex_flush = 1'b1;
                ex_mem_en   = 1'b1;
                mem_wb_en_o = 1'b1;
                stall_inc_s = 1'b1;
            end else begin
                pc_en       = 1'b1;
                if_id_en    = 1'b1;
                id_ex_en    = 1'b1;
                ex_mem_en   = 1'b1;
                mem_wb_en_o = 1'b1;
            end
        end
    end

    // State register and saturating event counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= RUN;
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (stall_inc_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
                stall_cnt_r <= stall_cnt_r + CNT_W'(1);
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (flush_inc_s && (flush_cnt_r != {CNT_W{1'b1}})) begin
                flush_cnt_r <= flush_cnt_r + CNT_W'(1);
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;

endmodule : pipe_hazard_ctrl
